// File: rtl/buf_pipe.sv
// buf_pipe: DEPTH-stage valid/data shift pipeline with optional inversion at
// capture, hold (en=0), synchronous flush of valid bits and a 16-bit wrapping
// counter of words emitted from the last stage.
module buf_pipe #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             inv,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             busy,
   output logic [15:0]      out_cnt
);

   logic [DEPTH-1:0] r_vld_p;
   logic [WIDTH-1:0] r_dat_p [DEPTH];
   logic [15:0]      r_cnt;
   logic             w_adv;
   logic             w_emit;

   // Inversion is applied only here, at capture into stage 0, so words already
   // in flight are unaffected when inv changes.
   function automatic logic [WIDTH-1:0] f_capture(input logic i_inv,
                                                  input logic [WIDTH-1:0] i_word);
      return i_inv ? ~i_word : i_word;
   endfunction

   assign w_adv  = en & ~flush;
   assign w_emit = w_adv & r_vld_p[DEPTH-1];

   // Stage valid bits: shift on advance, all cleared by flush regardless of en
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vld_p <= '0;
      end else if (flush) begin
         r_vld_p <= '0;
      end else if (en) begin
         r_vld_p[0] <= in_valid;
         for (int k = 1; k < DEPTH; k++) begin
            r_vld_p[k] <= r_vld_p[k-1];
         end
      end
   end

   // Stage data: shift on advance; on flush the stale words are kept (masked at output)
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++) begin
            r_dat_p[k] <= '0;
         end
      end else if (w_adv) begin
         r_dat_p[0] <= f_capture(inv, in_data);
         for (int k = 1; k < DEPTH; k++) begin
            r_dat_p[k] <= r_dat_p[k-1];
         end
      end
   end

   // Emitted-word counter: a word leaves on an advancing edge with a valid last stage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_emit) begin
         r_cnt <= r_cnt + 16'd1;
      end
   end

   // Outputs are driven purely from registers; data is masked when not valid
   assign out_valid = r_vld_p[DEPTH-1];
   assign out_data  = r_vld_p[DEPTH-1] ? r_dat_p[DEPTH-1] : '0;
   assign busy      = |r_vld_p;
   assign out_cnt   = r_cnt;

endmodule

// File: tb/tb_buf_pipe.sv
// Bench for buf_pipe: a DEPTH=4 and a DEPTH=1 instance share the stimulus.
// The reference model keeps a history of words accepted on advancing edges;
// the output of a DEPTH-D pipe is simply the entry accepted D advances ago.
module tb_buf_pipe;

   typedef struct packed {
      logic       v;
      logic [7:0] d;
   } ent_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        flush;
   logic        inv;
   logic        in_valid;
   logic [7:0]  in_data;

   logic        o4_valid, o1_valid;
   logic [7:0]  o4_data,  o1_data;
   logic        o4_busy,  o1_busy;
   logic [15:0] o4_cnt,   o1_cnt;

   int          n_cmp = 0;
   int          n_err = 0;

   ent_t        hist[$];
   logic [15:0] m_cnt4;
   logic [15:0] m_cnt1;

   buf_pipe #(.WIDTH(8), .DEPTH(4)) u_d4 (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .inv(inv),
      .in_valid(in_valid), .in_data(in_data),
      .out_valid(o4_valid), .out_data(o4_data), .busy(o4_busy), .out_cnt(o4_cnt)
   );

   buf_pipe #(.WIDTH(8), .DEPTH(1)) u_d1 (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .inv(inv),
      .in_valid(in_valid), .in_data(in_data),
      .out_valid(o1_valid), .out_data(o1_data), .busy(o1_busy), .out_cnt(o1_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t m_out(input int dep);
      ent_t e;
      e = '0;
      if (hist.size() >= dep) begin
         e = hist[hist.size()-dep];
         if (!e.v) e.d = '0;
      end
      return e;
   endfunction

   function automatic logic m_busy(input int dep);
      logic b;
      b = 1'b0;
      for (int i = 1; i <= dep; i++) begin
         if (hist.size() >= i) begin
            if (hist[hist.size()-i].v) b = 1'b1;
         end
      end
      return b;
   endfunction

   task automatic m_reset();
      hist.delete();
      m_cnt4 = '0;
      m_cnt1 = '0;
   endtask

   task automatic m_edge();
      ent_t e, o4, o1;
      if (flush) begin
         for (int i = 0; i < hist.size(); i++) hist[i].v = 1'b0;
      end else if (en) begin
         o4 = m_out(4);
         o1 = m_out(1);
         if (o4.v) m_cnt4 = m_cnt4 + 16'd1;
         if (o1.v) m_cnt1 = m_cnt1 + 16'd1;
         e.v = in_valid;
         e.d = inv ? ~in_data : in_data;
         hist.push_back(e);
         if (hist.size() > 16) void'(hist.pop_front());
      end
   endtask

   task automatic chk_all(input string tag);
      ent_t e4, e1;
      e4 = m_out(4);
      e1 = m_out(1);
      chk({tag, ".valid4"}, {31'd0, o4_valid}, {31'd0, e4.v});
      chk({tag, ".data4"},  {24'd0, o4_data},  {24'd0, e4.d});
      chk({tag, ".busy4"},  {31'd0, o4_busy},  {31'd0, m_busy(4)});
      chk({tag, ".cnt4"},   {16'd0, o4_cnt},   {16'd0, m_cnt4});
      chk({tag, ".valid1"}, {31'd0, o1_valid}, {31'd0, e1.v});
      chk({tag, ".data1"},  {24'd0, o1_data},  {24'd0, e1.d});
      chk({tag, ".busy1"},  {31'd0, o1_busy},  {31'd0, m_busy(1)});
      chk({tag, ".cnt1"},   {16'd0, o1_cnt},   {16'd0, m_cnt1});
   endtask

   // One clock edge: drive inputs away from the edge, update model, sample 1 ns later.
   task automatic step(input string tag, input logic e, input logic f, input logic i,
                       input logic v, input logic [7:0] d, input bit do_chk);
      en = e; flush = f; inv = i; in_valid = v; in_data = d;
      @(posedge clk);
      m_edge();
      #1;
      if (do_chk) chk_all(tag);
   endtask

   // Reset pulse placed between clock edges; outputs must clear before any edge.
   task automatic pulse_rst(input string tag);
      #2 rst = 1'b1;
      #1;
      m_reset();
      chk_all(tag);
      #1 rst = 1'b0;
   endtask

   initial begin
      logic [15:0] cnt_hold;
      rst = 1'b1; en = 1'b0; flush = 1'b0; inv = 1'b0; in_valid = 1'b0; in_data = '0;
      m_reset();
      #2;
      chk_all("reset");
      @(posedge clk);
      #1;
      chk_all("reset_edge");
      rst = 1'b0;

      // Latency / pass-through of a single word
      step("lat_e1", 1, 0, 0, 1, 8'hA5, 1);
      chk("lat_e1_v4", {31'd0, o4_valid}, 32'd0);
      chk("lat_e1_d1", {24'd0, o1_data}, 32'hA5);
      step("lat_e2", 1, 0, 0, 0, 8'h00, 1);
      step("lat_e3", 1, 0, 0, 0, 8'h00, 1);
      chk("lat_e3_v4", {31'd0, o4_valid}, 32'd0);
      step("lat_e4", 1, 0, 0, 0, 8'h00, 1);
      chk("lat_e4_v4", {31'd0, o4_valid}, 32'd1);
      chk("lat_e4_d4", {24'd0, o4_data}, 32'hA5);
      chk("lat_e4_c4", {16'd0, o4_cnt}, 32'd0);
      step("lat_e5", 1, 0, 0, 0, 8'h00, 1);
      chk("lat_e5_v4", {31'd0, o4_valid}, 32'd0);
      chk("lat_e5_c4", {16'd0, o4_cnt}, 32'd1);

      // Inversion sampled at capture only, back-to-back streaming
      step("inv_w0", 1, 0, 1, 1, 8'h00, 1);
      step("inv_w1", 1, 0, 1, 1, 8'h0F, 1);
      step("inv_w2", 1, 0, 1, 1, 8'hFF, 1);
      step("inv_o0", 1, 0, 0, 0, 8'h00, 1);
      chk("inv_o0_d4", {24'd0, o4_data}, 32'hFF);
      step("inv_o1", 1, 0, 0, 0, 8'h00, 1);
      chk("inv_o1_d4", {24'd0, o4_data}, 32'hF0);
      step("inv_o2", 1, 0, 0, 0, 8'h00, 1);
      chk("inv_o2_d4", {24'd0, o4_data}, 32'h00);
      chk("inv_o2_v4", {31'd0, o4_valid}, 32'd1);
      step("inv_drain", 1, 0, 0, 0, 8'h00, 1);

      // Stall with en=0 while full, then resume
      step("stl_f0", 1, 0, 0, 1, 8'h11, 1);
      step("stl_f1", 1, 0, 0, 1, 8'h22, 1);
      step("stl_f2", 1, 0, 0, 1, 8'h33, 1);
      step("stl_f3", 1, 0, 0, 1, 8'h44, 1);
      cnt_hold = o4_cnt;
      for (int i = 0; i < 5; i++) begin
         step("stl_hold", 0, 0, 1, 1, 8'h99, 1);
         chk("stl_hold_d4", {24'd0, o4_data}, 32'h11);
         chk("stl_hold_b4", {31'd0, o4_busy}, 32'd1);
         chk("stl_hold_c4", {16'd0, o4_cnt}, {16'd0, cnt_hold});
      end
      step("stl_r0", 1, 0, 0, 0, 8'h00, 1);
      chk("stl_r0_d4", {24'd0, o4_data}, 32'h22);
      step("stl_r1", 1, 0, 0, 0, 8'h00, 1);
      chk("stl_r1_d4", {24'd0, o4_data}, 32'h33);
      step("stl_r2", 1, 0, 0, 0, 8'h00, 1);
      chk("stl_r2_d4", {24'd0, o4_data}, 32'h44);
      step("stl_drain", 1, 0, 0, 0, 8'h00, 1);

      // Flush with en=0 drops in-flight words and the word presented that cycle
      step("fl_w0", 1, 0, 0, 1, 8'h51, 1);
      step("fl_w1", 1, 0, 0, 1, 8'h52, 1);
      step("fl_w2", 1, 0, 0, 1, 8'h53, 1);
      cnt_hold = o4_cnt;
      step("fl_do", 0, 1, 0, 1, 8'h77, 1);
      chk("fl_do_b4", {31'd0, o4_busy}, 32'd0);
      chk("fl_do_v4", {31'd0, o4_valid}, 32'd0);
      chk("fl_do_d4", {24'd0, o4_data}, 32'd0);
      chk("fl_do_c4", {16'd0, o4_cnt}, {16'd0, cnt_hold});
      for (int i = 0; i < 5; i++) begin
         step("fl_after", 1, 0, 0, 0, 8'h00, 1);
         chk("fl_after_v4", {31'd0, o4_valid}, 32'd0);
      end

      // Randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 9) == 0),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1);
      end

      // Asynchronous reset mid-stream with a full pipe and out_cnt=9
      pulse_rst("rst_pre");
      for (int i = 0; i < 13; i++) begin
         step("rst_fill", 1, 0, 0, 1, 8'($urandom), 1);
      end
      chk("rst_fill_c4", {16'd0, o4_cnt}, 32'd9);
      chk("rst_fill_b4", {31'd0, o4_busy}, 32'd1);
      pulse_rst("rst_mid");
      chk("rst_mid_c4", {16'd0, o4_cnt}, 32'd0);
      chk("rst_mid_v4", {31'd0, o4_valid}, 32'd0);
      step("rst_first", 1, 0, 0, 1, 8'h3C, 1);

      // Counter wrap: stream until the DEPTH=4 count reaches 65534
      pulse_rst("wrap_rst");
      for (int i = 0; i < 65538; i++) begin
         step("wrap_fill", 1, 0, 0, 1, 8'(i), 0);
      end
      chk_all("wrap_pre");
      chk("wrap_pre_c4", {16'd0, o4_cnt}, 32'd65534);
      step("wrap_a", 1, 0, 0, 1, 8'h01, 1);
      chk("wrap_a_c4", {16'd0, o4_cnt}, 32'd65535);
      step("wrap_b", 1, 0, 0, 1, 8'h02, 1);
      chk("wrap_b_c4", {16'd0, o4_cnt}, 32'd0);
      step("wrap_c", 1, 0, 0, 1, 8'h03, 1);
      chk("wrap_c_c4", {16'd0, o4_cnt}, 32'd1);

      // Single-stage pipe: one-edge latency
      pulse_rst("d1_rst");
      step("d1_e1", 1, 0, 0, 1, 8'hA5, 1);
      chk("d1_e1_v1", {31'd0, o1_valid}, 32'd1);
      chk("d1_e1_d1", {24'd0, o1_data}, 32'hA5);
      step("d1_e2", 1, 0, 0, 0, 8'h00, 1);
      chk("d1_e2_c1", {16'd0, o1_cnt}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/buf_pipe.md
BUF_PIPE -- requirements
Module: buf_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, meaning data word width in bits (1..32).
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning number of register stages (1..16).
REQ-003 The module SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 The module SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The module SHALL have port en  input  1  advance enable; 1 shifts the pipeline, 0 holds all state.
REQ-006 The module SHALL have port flush  input  1  synchronous clear of all stage valid bits.
REQ-007 The module SHALL have port inv  input  1  mode; 1 means the word captured into stage 0 is bitwise inverted, 0 means it passes unchanged.
REQ-008 The module SHALL have port in_valid  input  1  in_data carries a word this cycle.
REQ-009 The module SHALL have port in_data  input  WIDTH  input word.
REQ-010 The module SHALL have port out_valid  output  1  valid bit of stage DEPTH-1.
REQ-011 The module SHALL have port out_data  output  WIDTH  data of stage DEPTH-1, forced to 0 when out_valid=0.
REQ-012 The module SHALL have port busy  output  1  OR of all stage valid bits.
REQ-013 The module SHALL have port out_cnt  output  16  count of words emitted.

Function
REQ-014 Each stage k SHALL hold a valid bit v[k] and a WIDTH-bit data register d[k].
REQ-015 On a rising edge with en=1 and flush=0: v[0]<=in_valid, d[0]<=inv ? ~in_data : in_data, and v[k]<=v[k-1], d[k]<=d[k-1] for k=1..DEPTH-1.
REQ-016 The inv value SHALL be sampled only at stage-0 capture; changing inv SHALL NOT alter words already in the pipeline.
REQ-017 On a rising edge with en=0 and flush=0, every v[k], every d[k] and out_cnt SHALL hold.
REQ-018 On a rising edge with flush=1, all v[k] SHALL clear to 0 regardless of en; a word presented on in_valid that cycle SHALL be dropped; d[k] MAY keep stale values (masked by REQ-011); out_cnt SHALL hold.
REQ-019 Latency SHALL be exactly DEPTH enabled edges: a word accepted at edge N with en=1 on every following edge appears with out_valid=1 after edge N+DEPTH-1.
REQ-020 With en continuously 1, the pipeline SHALL accept one word per cycle with no bubbles inserted; gaps in in_valid SHALL propagate as gaps in out_valid.
REQ-021 A word SHALL count as emitted on a rising edge where en=1, flush=0 and out_valid=1; out_cnt SHALL then increment by 1.
REQ-022 out_cnt SHALL wrap from 65535 to 0 without saturation or flag.
REQ-023 busy SHALL be combinational from the v[k] registers only; out_valid and out_data SHALL be combinational from stage DEPTH-1 registers only, with no combinational path from any input.
REQ-024 For DEPTH=1, stage 0 SHALL be the output stage and latency SHALL be 1 edge.

Reset
REQ-025 While rst=1, all v[k], all d[k] and out_cnt SHALL be 0 immediately, independent of clk.
REQ-026 Out of reset: out_valid=0, out_data=0, busy=0, out_cnt=0.
REQ-027 Reset asserted mid-stream SHALL discard all in-flight words; the first edge after rst deasserts SHALL behave per REQ-015 to REQ-018.

Verification (WIDTH=8, DEPTH=4 unless stated)
REQ-028 Latency/pass: en=1, inv=0, one word 0xA5 at edge 1 -> out_valid=1, out_data=0xA5 after edge 4 only, out_cnt=1 after edge 5.
REQ-029 Invert/streaming: en=1, inv=1, words 0x00,0x0F,0xFF on consecutive edges, inv toggled to 0 mid-stream -> outputs 0xFF,0xF0,0x00 back-to-back; only words captured with inv=1 are inverted.
REQ-030 Stall: fill with 0x11,0x22,0x33,0x44, hold en=0 for 5 cycles -> out_data stays 0x11, busy=1, out_cnt constant; resume en=1 -> 0x22,0x33,0x44 follow on consecutive cycles.
REQ-031 Flush: 3 words in flight, flush=1 with en=0 and in_valid=1 (0x77) -> next cycle busy=0, out_valid=0, out_data=0; 0x77 never appears.
REQ-032 Async reset: rst pulsed between clock edges with pipeline full and out_cnt=9 -> outputs 0 and out_cnt=0 before next edge.
REQ-033 Wrap: preload out_cnt to 65534 via streaming, emit 3 words -> out_cnt sequence 65535, 0, 1; repeat REQ-028 with DEPTH=1 -> 0xA5 out after edge 1.
